// File: rtl/buffer_index_selector_if.sv
// Request/response bundle between the candidate-list generator, the index
// selector and the buffer scheduler. Parameter BS must match the selector.
// master = requester/consumer side, slave = buffer_index_selector.
interface buffer_index_selector_if #(
  parameter int BS = 16
) ();
  localparam int IW = $clog2(BS);

  logic [BS-1:0] candidate_list;
  logic [IW-1:0] random_number;
  logic          req_valid;
  logic          req_ready;
  logic          hist_clear;
  logic          idx_valid;
  logic [IW-1:0] idx;
  logic          idx_ready;
  logic          relaxed;
  logic          empty_err;
  logic [IW:0]   count;

  modport master (
    output candidate_list, random_number, req_valid, hist_clear, idx_ready,
    input  req_ready, idx_valid, idx, relaxed, empty_err, count
  );

  modport slave (
    input  candidate_list, random_number, req_valid, hist_clear, idx_ready,
    output req_ready, idx_valid, idx, relaxed, empty_err, count
  );
endinterface

// File: rtl/buffer_index_selector.sv
// Picks one eligible buffer index: history-masked compaction, random modulo select.
// Latency: count 1 cycle after accept, idx_valid/empty_err 2 cycles after accept.
// Backpressure: req_ready only in IDLE; idx held stable until idx_ready.
// Optional IDXSEL_LFSR_EN: internal 16-bit Galois LFSR replaces random_number.
module buffer_index_selector #(
  parameter  int BS   = 16,
  parameter  int HIST = 3,
  localparam int IW   = $clog2(BS)
) (
  input  logic                     clk,
  input  logic                     rst,
  buffer_index_selector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COMPACT, SELECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [BS-1:0]   cand_q, cand_d;
  logic            relax_q, relax_d;
  logic [IW-1:0]   rnd_q, rnd_d;
  logic [IW-1:0]   tbl_q [BS];
  logic [IW-1:0]   tbl_d [BS];
  logic [IW-1:0]   tbl_c [BS];
  logic [IW:0]     count_q, count_d;
  logic [IW:0]     pop_c;
  logic [IW-1:0]   hist_idx_q [HIST];
  logic [IW-1:0]   hist_idx_d [HIST];
  logic [HIST-1:0] hist_vld_q, hist_vld_d, hist_vld_base;
  logic [IW-1:0]   idx_q, idx_d;
  logic            idx_vld_q, idx_vld_d;
  logic            relaxed_q, relaxed_d;
  logic            empty_q, empty_d;
  logic [BS-1:0]   mask_c;
  logic [IW:0]     sel_c;
  logic [IW-1:0]   pick_c;
  logic [IW-1:0]   rnd_src;

`ifdef IDXSEL_LFSR_EN
  logic [15:0] lfsr_q;

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign rnd_src = lfsr_q[IW-1:0];
`else
  assign rnd_src = bus.random_number;
`endif

  // One-hot OR of all valid history entries
  always_comb begin
    mask_c = '0;
    for (int h = 0; h < HIST; h++) begin
      if (hist_vld_q[h]) mask_c[hist_idx_q[h]] = 1'b1;
    end
  end

  // Compact set bits of cand_q into an ascending table and count them
  always_comb begin
    for (int k = 0; k < BS; k++) tbl_c[k] = '0;
    pop_c = '0;
    for (int i = 0; i < BS; i++) begin
      if (cand_q[i]) begin
        tbl_c[pop_c[IW-1:0]] = IW'(i);
        pop_c = pop_c + 1'b1;
      end
    end
  end

  // Random modulo over the compacted table; guarded against count of zero
  always_comb begin
    sel_c  = '0;
    pick_c = '0;
    if (count_q != '0) sel_c = {1'b0, rnd_q} % count_q;
    for (int k = 0; k < BS; k++) begin
      if (sel_c == (IW+1)'(k)) pick_c = tbl_q[k];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    relax_d    = relax_q;
    rnd_d      = rnd_q;
    tbl_d      = tbl_q;
    count_d    = count_q;
    hist_idx_d = hist_idx_q;
    idx_d      = idx_q;
    idx_vld_d  = idx_vld_q;
    relaxed_d  = relaxed_q;
    empty_d    = 1'b0;
    // A clear lands before any push on the same edge
    hist_vld_base = bus.hist_clear ? '0 : hist_vld_q;
    hist_vld_d    = hist_vld_base;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if ((bus.candidate_list & ~mask_c) != '0) begin
            cand_d  = bus.candidate_list & ~mask_c;
            relax_d = 1'b0;
          end else begin
            // Every candidate was recently issued: fall back to the raw list
            cand_d  = bus.candidate_list;
            relax_d = 1'b1;
          end
          rnd_d   = rnd_src;
          state_d = COMPACT;
        end
      end
      COMPACT: begin
        tbl_d   = tbl_c;
        count_d = pop_c;
        state_d = SELECT;
      end
      SELECT: begin
        if (count_q == '0) begin
          empty_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d     = pick_c;
          relaxed_d = relax_q;
          idx_vld_d = 1'b1;
          for (int h = 1; h < HIST; h++) begin
            hist_idx_d[h] = hist_idx_q[h-1];
            hist_vld_d[h] = hist_vld_base[h-1];
          end
          hist_idx_d[0] = pick_c;
          hist_vld_d[0] = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.idx_ready) begin
          idx_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      relax_q    <= 1'b0;
      rnd_q      <= '0;
      tbl_q      <= '{default: '0};
      count_q    <= '0;
      hist_idx_q <= '{default: '0};
      hist_vld_q <= '0;
      idx_q      <= '0;
      idx_vld_q  <= 1'b0;
      relaxed_q  <= 1'b0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      relax_q    <= relax_d;
      rnd_q      <= rnd_d;
      tbl_q      <= tbl_d;
      count_q    <= count_d;
      hist_idx_q <= hist_idx_d;
      hist_vld_q <= hist_vld_d;
      idx_q      <= idx_d;
      idx_vld_q  <= idx_vld_d;
      relaxed_q  <= relaxed_d;
      empty_q    <= empty_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.idx_valid = idx_vld_q;
  assign bus.idx       = idx_q;
  assign bus.relaxed   = relaxed_q;
  assign bus.empty_err = empty_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_buffer_index_selector.sv
// Randomized bench for buffer_index_selector against a list-based reference model.
module tb_buffer_index_selector;
  localparam int BS   = 16;
  localparam int HIST = 3;
  localparam int IW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_index_selector_if #(.BS(BS)) bus ();

  buffer_index_selector #(.BS(BS), .HIST(HIST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int hist_q[$];   // most recent issued index at the front

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: eligible = candidates not in history (ascending); fall back to
  // all candidates if none survive; pick the (rnd mod size)-th entry.
  function automatic void model_pick(input logic [15:0] cand, input int rnd,
                                     output int cnt, output int pick, output bit rel);
    int  elig[$];
    bit  hit;
    for (int i = 0; i < BS; i++) begin
      if (cand[i]) begin
        hit = 1'b0;
        foreach (hist_q[j]) if (hist_q[j] == i) hit = 1'b1;
        if (!hit) elig.push_back(i);
      end
    end
    rel = 1'b0;
    if (elig.size() == 0) begin
      rel = 1'b1;
      for (int i = 0; i < BS; i++) if (cand[i]) elig.push_back(i);
    end
    cnt  = elig.size();
    pick = 0;
    if (cnt > 0) pick = elig[rnd % cnt];
  endfunction

  task automatic clear_hist();
    bus.hist_clear = 1'b1;
    @(negedge clk);
    bus.hist_clear = 1'b0;
    hist_q.delete();
  endtask

  // One full request; called and returns at a negedge
  task automatic do_req(input logic [15:0] cand, input logic [3:0] rnd,
                        input int hold, input bit clr_sel);
    int n, cnt, pick;
    bit rel;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    model_pick(cand, int'(rnd), cnt, pick, rel);
    bus.candidate_list = cand;
    bus.random_number  = rnd;
    bus.req_valid      = 1'b1;
    @(negedge clk);                       // COMPACT
    bus.req_valid      = 1'b0;
    bus.candidate_list = 16'($urandom);
    bus.random_number  = 4'($urandom);
    check("busy_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);                       // SELECT
    check("count", 32'(bus.count), 32'(cnt));
    if (clr_sel) bus.hist_clear = 1'b1;
    @(negedge clk);                       // result visible
    bus.hist_clear = 1'b0;
    if (clr_sel) hist_q.delete();
    if (cnt == 0) begin
      check("empty_pulse", {31'd0, bus.empty_err}, 32'd1);
      check("empty_novld", {31'd0, bus.idx_valid}, 32'd0);
      @(negedge clk);
      check("empty_once", {31'd0, bus.empty_err}, 32'd0);
      check("empty_ready", {31'd0, bus.req_ready}, 32'd1);
    end else begin
      check("idx_valid", {31'd0, bus.idx_valid}, 32'd1);
      check("idx", 32'(bus.idx), 32'(pick));
      check("relaxed", {31'd0, bus.relaxed}, {31'd0, rel});
      check("no_empty", {31'd0, bus.empty_err}, 32'd0);
      hist_q.push_front(pick);
      if (hist_q.size() > HIST) void'(hist_q.pop_back());
      for (int i = 0; i < hold; i++) begin
        bus.candidate_list = 16'($urandom);
        @(negedge clk);
        check("hold_idx", 32'(bus.idx), 32'(pick));
        check("hold_vld", {31'd0, bus.idx_valid}, 32'd1);
        check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.idx_ready = 1'b1;
      @(negedge clk);
      bus.idx_ready = 1'b0;
      check("post_vld", {31'd0, bus.idx_valid}, 32'd0);
      check("post_ready", {31'd0, bus.req_ready}, 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vld"},   {31'd0, bus.idx_valid}, 32'd0);
    check({tag, "_idx"},   32'(bus.idx), 32'd0);
    check({tag, "_rlx"},   {31'd0, bus.relaxed}, 32'd0);
    check({tag, "_err"},   {31'd0, bus.empty_err}, 32'd0);
    check({tag, "_cnt"},   32'(bus.count), 32'd0);
    check({tag, "_rdy"},   {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] c;
    bus.candidate_list = '0;
    bus.random_number  = '0;
    bus.req_valid      = 1'b0;
    bus.hist_clear     = 1'b0;
    bus.idx_ready      = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic selection from empty history
    do_req(16'h00F0, 4'd5, 0, 1'b0);
    // Rotation through the history exclusion
    repeat (5) do_req(16'h000F, 4'd0, 0, 1'b0);
    // Relax fallback with history {0,1,2}
    clear_hist();
    do_req(16'h0001, 4'd0, 0, 1'b0);
    do_req(16'h0002, 4'd0, 0, 1'b0);
    do_req(16'h0004, 4'd0, 0, 1'b0);
    do_req(16'h0003, 4'd3, 0, 1'b0);
    // Empty candidate list; following request shows history untouched
    do_req(16'h0000, 4'($urandom), 0, 1'b0);
    do_req(16'h000F, 4'd0, 0, 1'b0);
    // Consumer stall for 5 cycles
    do_req(16'h0F0F, 4'd7, 5, 1'b0);
    // Clear coinciding with a push
    do_req(16'h00FF, 4'd2, 1, 1'b1);
    do_req(16'h00FF, 4'd0, 0, 1'b0);
    // Full candidate vector
    do_req(16'hFFFF, 4'd15, 0, 1'b0);

    // Reset during COMPACT drops the request without an error pulse
    bus.candidate_list = 16'h00F0;
    bus.random_number  = 4'd1;
    bus.req_valid      = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist_q.delete();
    check_reset_vals("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_noerr", {31'd0, bus.empty_err}, 32'd0);
      check("midrst_novld", {31'd0, bus.idx_valid}, 32'd0);
    end
    do_req(16'h000F, 4'd0, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       c = 16'h0000;
        1, 2:    c = 16'(1 << $urandom_range(0, 15));
        3, 4, 5: c = 16'($urandom & $urandom);
        default: c = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) clear_hist();
      do_req(c, 4'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_index_selector.md
# buffer_index_selector

Parametrised, handshaked successor to the ESM buffer mapping table. On each request it compacts the eligible-buffer vector into an ordered table, drops recently issued indices held in a configurable-depth exclusion history, and picks one survivor with a random modulo. It sits between the candidate-list generator and the buffer write/read scheduler, and has a history-relax fallback and an explicit empty error.

## Interface
- `BS`, 16: buffer count. Power of two, 4..256.
- `HIST`, 3: exclusion history depth, 1..8.
- `IW`, `$clog2(BS)`: index width. Derived; do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `candidate_list`  in  BS  bit i = buffer i eligible.
- `random_number`  in  IW  external random value. Ignored when `IDXSEL_LFSR_EN` is defined.
- `req_valid`  in  1  request a new index.
- `req_ready`  out  1  high only in IDLE.
- `hist_clear`  in  1  clear the exclusion history.
- `idx_valid`  out  1  `idx` is valid.
- `idx`  out  IW  selected buffer index.
- `idx_ready`  in  1  consumer accepts `idx`.
- `relaxed`  out  1  history was bypassed for the current `idx`.
- `empty_err`  out  1  one-cycle pulse: request had no candidates.
- `count`  out  IW+1  entries in the last compacted table, 0..BS.

## Operation
FSM states are IDLE, COMPACT, SELECT, HOLD.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` (the accept edge):
    - mask = OR of one-hots of the valid history entries.
    - If (`candidate_list` & ~mask) != 0: `cand_q` = `candidate_list` & ~mask, `relax_q`=0.
    - Else: `cand_q` = `candidate_list`, `relax_q`=1.
    - Sample `rnd_q`.
    - Go to COMPACT.
- **COMPACT**
  - table[k] = k-th set bit of `cand_q`, in ascending index order. Unused entries = 0.
  - `count` = popcount(`cand_q`), registered.
  - Go to SELECT.
- **SELECT**
  - If `count`==0: pulse `empty_err` for one cycle; history unchanged; go to IDLE.
  - Else:
    - `idx` = table[`rnd_q` % `count`].
    - `relaxed` = `relax_q`.
    - Shift `idx` into the history; the oldest entry drops.
    - `idx_valid`=1; go to HOLD.
  - The modulo uses IW+1-bit arithmetic. Bias for non-power-of-two counts is accepted.
- **HOLD**
  - `idx`, `idx_valid` and `relaxed` stay stable until `idx_ready`=1.
  - On that handshake edge: `idx_valid`=0, go to IDLE.
- **History**
  - HIST entries, each an IW-bit value plus a valid bit.
  - `hist_clear` clears all valid bits.
  - If `hist_clear` and a SELECT push occur on the same edge, the clear applies first, so the history holds only the new entry.
- `candidate_list` and `random_number` are ignored outside the accept edge.

## Timing
- Accept at edge T. `count` is valid after T+1. `idx_valid` or the `empty_err` pulse appears after T+2.
- `req_ready` is high again from:
  - the cycle after the `idx` handshake, or
  - the cycle after the `empty_err` pulse.
- Minimum request-to-request period: 4 clocks when `idx_ready` is tied high.
- Reset values: `idx_valid`=0, `idx`=0, `relaxed`=0, `empty_err`=0, `count`=0, `req_ready`=1 (state IDLE), history invalid, table zero.
- `rst` in any state overrides everything. Any in-flight request is dropped with no `empty_err`.

## Configuration
- `IDXSEL_LFSR_EN` defined:
  - Internal 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Reset seed 16'hACE1. Advances every clock.
  - `rnd_q` = LFSR[IW-1:0] at the accept edge.
  - `random_number` is ignored.
- Undefined:
  - No LFSR is instantiated.
  - `rnd_q` = `random_number` at the accept edge.

## Test plan
All scenarios use BS=16, HIST=3, macro undefined unless noted.
1. History empty, `candidate_list`=16'h00F0, `random_number`=5 -> `count`=4 after T+1; `idx`=5, `idx_valid` after T+2, `relaxed`=0.
2. Five requests, `candidate_list`=16'h000F, `random_number`=0 each -> `idx` sequence 0,1,2,3,0.
3. History {0,1,2}, `candidate_list`=16'h0003, `random_number`=3 -> `relaxed`=1, `count`=2, `idx`=1.
4. `candidate_list`=0 -> `empty_err` high for exactly one cycle after T+2; `idx_valid` stays 0; `req_ready`=1 the next cycle; history unchanged.
5. `idx_ready` held low 5 cycles with `candidate_list` toggling -> `idx` and `idx_valid` stable, `req_ready`=0; handshake on cycle 6 -> IDLE.
6. `rst` pulsed during COMPACT -> next cycle all outputs at reset values and history empty. With `IDXSEL_LFSR_EN`, a request accepted on the first clock after reset sees `rnd_q`=4'h1.
